// File: rtl/jelly_axi4_slave_write_mem.sv
// AXI4 write-channel slave: accepts one AW/W/B burst at a time and turns each
// accepted data beat into a registered write on a single-port memory.
module jelly_axi4_slave_write_mem #(
  parameter int AXI4_ID_WIDTH   = 6,
  parameter int AXI4_ADDR_WIDTH = 32,
  parameter int AXI4_DATA_SIZE  = 2,
  parameter int AXI4_DATA_WIDTH = (8 << AXI4_DATA_SIZE),
  parameter int AXI4_STRB_WIDTH = (1 << AXI4_DATA_SIZE),
  parameter int AXI4_LEN_WIDTH  = 8,
  parameter int MEM_ADDR_WIDTH  = 10
) (
  input  logic                       s_axi4_aresetn,
  input  logic                       s_axi4_aclk,
  input  logic [AXI4_ID_WIDTH-1:0]   s_axi4_awid,
  input  logic [AXI4_ADDR_WIDTH-1:0] s_axi4_awaddr,
  input  logic [AXI4_LEN_WIDTH-1:0]  s_axi4_awlen,
  input  logic [2:0]                 s_axi4_awsize,
  input  logic [1:0]                 s_axi4_awburst,
  input  logic                       s_axi4_awvalid,
  output logic                       s_axi4_awready,
  input  logic [AXI4_DATA_WIDTH-1:0] s_axi4_wdata,
  input  logic [AXI4_STRB_WIDTH-1:0] s_axi4_wstrb,
  input  logic                       s_axi4_wlast,
  input  logic                       s_axi4_wvalid,
  output logic                       s_axi4_wready,
  output logic [AXI4_ID_WIDTH-1:0]   s_axi4_bid,
  output logic [1:0]                 s_axi4_bresp,
  output logic                       s_axi4_bvalid,
  input  logic                       s_axi4_bready,
  output logic                       m_mem_en,
  output logic [AXI4_STRB_WIDTH-1:0] m_mem_we,
  output logic [MEM_ADDR_WIDTH-1:0]  m_mem_addr,
  output logic [AXI4_DATA_WIDTH-1:0] m_mem_wdata
);

  localparam logic [1:0] BURST_FIXED = 2'd0;
  localparam logic [1:0] BURST_WRAP  = 2'd2;
  localparam logic [1:0] BURST_RSVD  = 2'd3;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    RESP
  } state_t;

  state_t state_q, state_d;

  logic [AXI4_ID_WIDTH-1:0]   id_q, id_d;
  logic [1:0]                 burst_q, burst_d;
  logic [AXI4_LEN_WIDTH-1:0]  len_q, len_d;
  logic [MEM_ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic [AXI4_LEN_WIDTH-1:0]  count_q, count_d;
  logic                       err_q, err_d;
  logic                       wlastErr_q, wlastErr_d;

  logic                       awready_q, awready_d;
  logic                       wready_q, wready_d;
  logic                       bvalid_q, bvalid_d;
  logic [1:0]                 bresp_q, bresp_d;
  logic                       memEn_q, memEn_d;
  logic [AXI4_STRB_WIDTH-1:0] memWe_q, memWe_d;
  logic [MEM_ADDR_WIDTH-1:0]  memAddr_q, memAddr_d;
  logic [AXI4_DATA_WIDTH-1:0] memWdata_q, memWdata_d;

  logic                       awHs;
  logic                       wHs;
  logic                       bHs;
  logic                       lastBeat;
  logic                       wlastBad;
  logic                       wrapLenLegal;
  logic                       awErr;
  logic [MEM_ADDR_WIDTH-1:0]  wrapMask;
  logic [MEM_ADDR_WIDTH-1:0]  addrInc;
  logic [MEM_ADDR_WIDTH-1:0]  addrNext;
  logic                       unusedBits;

  assign awHs     = s_axi4_awvalid && awready_q;
  assign wHs      = s_axi4_wvalid && wready_q;
  assign bHs      = s_axi4_bready && bvalid_q;
  assign lastBeat = (count_q == len_q);
  assign wlastBad = (s_axi4_wlast != lastBeat);

  // Only power-of-two WRAP lengths of 2..16 beats are legal.
  assign wrapLenLegal = (s_axi4_awlen == AXI4_LEN_WIDTH'(1))
                     || (s_axi4_awlen == AXI4_LEN_WIDTH'(3))
                     || (s_axi4_awlen == AXI4_LEN_WIDTH'(7))
                     || (s_axi4_awlen == AXI4_LEN_WIDTH'(15));
  assign awErr = (s_axi4_awburst == BURST_RSVD)
              || ((s_axi4_awburst == BURST_WRAP) && !wrapLenLegal);

  // For a legal WRAP burst len itself is the mask of the wrapping low bits.
  assign wrapMask = MEM_ADDR_WIDTH'(len_q);
  assign addrInc  = addr_q + MEM_ADDR_WIDTH'(1);

  always_comb begin
    addrNext = addrInc;
    case (burst_q)
      BURST_FIXED: addrNext = addr_q;
      BURST_WRAP:  addrNext = (addr_q & ~wrapMask) | (addrInc & wrapMask);
      default:     addrNext = addrInc;
    endcase
  end

  assign unusedBits = ^{s_axi4_awsize, s_axi4_awaddr};

  always_ff @(posedge s_axi4_aclk or negedge s_axi4_aresetn) begin
    if (!s_axi4_aresetn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (awHs) state_d = DATA;
      DATA: if (wHs && lastBeat) state_d = RESP;
      RESP: if (bHs) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    awready_d  = 1'b0;
    wready_d   = 1'b0;
    bvalid_d   = 1'b0;
    bresp_d    = bresp_q;
    memEn_d    = wHs;
    memWe_d    = (wHs && !err_q) ? s_axi4_wstrb : '0;
    memAddr_d  = wHs ? addr_q : memAddr_q;
    memWdata_d = wHs ? s_axi4_wdata : memWdata_q;
    case (state_q)
      IDLE: begin
        awready_d = !awHs;
        wready_d  = awHs;
      end
      DATA: begin
        wready_d = !(wHs && lastBeat);
        if (wHs && lastBeat) begin
          bvalid_d = 1'b1;
          bresp_d  = (err_q || wlastErr_q || wlastBad) ? RESP_SLVERR : RESP_OKAY;
        end
      end
      RESP: begin
        bvalid_d  = !bHs;
        awready_d = bHs;
      end
      default: ;
    endcase
  end

  // A wlast mismatch only poisons the response; it never suppresses writes.
  always_comb begin
    id_d       = id_q;
    burst_d    = burst_q;
    len_d      = len_q;
    addr_d     = addr_q;
    count_d    = count_q;
    err_d      = err_q;
    wlastErr_d = wlastErr_q;
    if (awHs) begin
      id_d       = s_axi4_awid;
      burst_d    = s_axi4_awburst;
      len_d      = s_axi4_awlen;
      addr_d     = s_axi4_awaddr[AXI4_DATA_SIZE +: MEM_ADDR_WIDTH];
      count_d    = '0;
      err_d      = awErr;
      wlastErr_d = 1'b0;
    end
    if (wHs) begin
      addr_d     = addrNext;
      count_d    = count_q + AXI4_LEN_WIDTH'(1);
      wlastErr_d = wlastErr_q || wlastBad;
    end
  end

  always_ff @(posedge s_axi4_aclk or negedge s_axi4_aresetn) begin
    if (!s_axi4_aresetn) begin
      id_q       <= '0;
      burst_q    <= '0;
      len_q      <= '0;
      addr_q     <= '0;
      count_q    <= '0;
      err_q      <= 1'b0;
      wlastErr_q <= 1'b0;
      awready_q  <= 1'b0;
      wready_q   <= 1'b0;
      bvalid_q   <= 1'b0;
      bresp_q    <= '0;
      memEn_q    <= 1'b0;
      memWe_q    <= '0;
      memAddr_q  <= '0;
      memWdata_q <= '0;
    end else begin
      id_q       <= id_d;
      burst_q    <= burst_d;
      len_q      <= len_d;
      addr_q     <= addr_d;
      count_q    <= count_d;
      err_q      <= err_d;
      wlastErr_q <= wlastErr_d;
      awready_q  <= awready_d;
      wready_q   <= wready_d;
      bvalid_q   <= bvalid_d;
      bresp_q    <= bresp_d;
      memEn_q    <= memEn_d;
      memWe_q    <= memWe_d;
      memAddr_q  <= memAddr_d;
      memWdata_q <= memWdata_d;
    end
  end

  assign s_axi4_awready = awready_q;
  assign s_axi4_wready  = wready_q;
  assign s_axi4_bvalid  = bvalid_q;
  assign s_axi4_bid     = id_q;
  assign s_axi4_bresp   = bresp_q;
  assign m_mem_en       = memEn_q;
  assign m_mem_we       = memWe_q;
  assign m_mem_addr     = memAddr_q;
  assign m_mem_wdata    = memWdata_q;

endmodule

// File: tb/tb_jelly_axi4_slave_write_mem.sv
// Self-checking bench for jelly_axi4_slave_write_mem: directed bursts plus random
// bursts, compared against a burst-level address/response model.
module tb_jelly_axi4_slave_write_mem;

  localparam int IDW = 6;
  localparam int AW  = 32;
  localparam int DS  = 2;
  localparam int DW  = 32;
  localparam int SW  = 4;
  localparam int LW  = 8;
  localparam int MAW = 10;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [IDW-1:0] s_axi4_awid = '0;
  logic [AW-1:0]  s_axi4_awaddr = '0;
  logic [LW-1:0]  s_axi4_awlen = '0;
  logic [2:0]     s_axi4_awsize = 3'd2;
  logic [1:0]     s_axi4_awburst = '0;
  logic           s_axi4_awvalid = 1'b0;
  logic           s_axi4_awready;
  logic [DW-1:0]  s_axi4_wdata = '0;
  logic [SW-1:0]  s_axi4_wstrb = '0;
  logic           s_axi4_wlast = 1'b0;
  logic           s_axi4_wvalid = 1'b0;
  logic           s_axi4_wready;
  logic [IDW-1:0] s_axi4_bid;
  logic [1:0]     s_axi4_bresp;
  logic           s_axi4_bvalid;
  logic           s_axi4_bready = 1'b1;
  logic           m_mem_en;
  logic [SW-1:0]  m_mem_we;
  logic [MAW-1:0] m_mem_addr;
  logic [DW-1:0]  m_mem_wdata;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [MAW-1:0] addr;
    logic [SW-1:0]  we;
    logic [DW-1:0]  data;
    bit             careAddr;
  } beat_t;

  beat_t expQ[$];
  beat_t capQ[$];

  always #5 clk = ~clk;

  jelly_axi4_slave_write_mem #(
    .AXI4_ID_WIDTH  (IDW),
    .AXI4_ADDR_WIDTH(AW),
    .AXI4_DATA_SIZE (DS),
    .AXI4_DATA_WIDTH(DW),
    .AXI4_STRB_WIDTH(SW),
    .AXI4_LEN_WIDTH (LW),
    .MEM_ADDR_WIDTH (MAW)
  ) dut (
    .s_axi4_aresetn(rst_n),
    .s_axi4_aclk   (clk),
    .s_axi4_awid   (s_axi4_awid),
    .s_axi4_awaddr (s_axi4_awaddr),
    .s_axi4_awlen  (s_axi4_awlen),
    .s_axi4_awsize (s_axi4_awsize),
    .s_axi4_awburst(s_axi4_awburst),
    .s_axi4_awvalid(s_axi4_awvalid),
    .s_axi4_awready(s_axi4_awready),
    .s_axi4_wdata  (s_axi4_wdata),
    .s_axi4_wstrb  (s_axi4_wstrb),
    .s_axi4_wlast  (s_axi4_wlast),
    .s_axi4_wvalid (s_axi4_wvalid),
    .s_axi4_wready (s_axi4_wready),
    .s_axi4_bid    (s_axi4_bid),
    .s_axi4_bresp  (s_axi4_bresp),
    .s_axi4_bvalid (s_axi4_bvalid),
    .s_axi4_bready (s_axi4_bready),
    .m_mem_en      (m_mem_en),
    .m_mem_we      (m_mem_we),
    .m_mem_addr    (m_mem_addr),
    .m_mem_wdata   (m_mem_wdata)
  );

  // Record every memory strobe just after the edge that produced it.
  always @(posedge clk) begin : monitor
    beat_t b;
    #1;
    if (m_mem_en === 1'b1) begin
      b.addr = m_mem_addr;
      b.we = m_mem_we;
      b.data = m_mem_wdata;
      b.careAddr = 1'b1;
      capQ.push_back(b);
    end
  end

  initial begin : watchdog
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Word address of beat i, derived from the burst rules rather than any register view.
  function automatic logic [MAW-1:0] modelAddr(input logic [MAW-1:0] base, input logic [1:0] burst,
                                               input int len, input int i);
    int b;
    int span;
    b = int'(base);
    span = len + 1;
    case (burst)
      2'd0:    return base;
      2'd2:    return MAW'((b / span) * span + ((b % span) + i) % span);
      default: return MAW'((b + i) % (1 << MAW));
    endcase
  endfunction

  function automatic bit modelErr(input logic [1:0] burst, input int len);
    if (burst == 2'd3) return 1'b1;
    if (burst == 2'd2) return !(len == 1 || len == 3 || len == 7 || len == 15);
    return 1'b0;
  endfunction

  task automatic compareWrites(input string tag);
    beat_t e;
    beat_t c;
    checkOutput({tag, "_wrcount"}, 64'(capQ.size()), 64'(expQ.size()));
    while (expQ.size() > 0 && capQ.size() > 0) begin
      e = expQ.pop_front();
      c = capQ.pop_front();
      checkOutput({tag, "_we"}, 64'(c.we), 64'(e.we));
      if (e.careAddr) begin
        checkOutput({tag, "_addr"}, 64'(c.addr), 64'(e.addr));
        checkOutput({tag, "_data"}, 64'(c.data), 64'(e.data));
      end
    end
    expQ.delete();
    capQ.delete();
  endtask

  // Drives one burst from a negedge; abortAfter>=0 stops after that many beats with no B phase.
  task automatic applyStimulus(input string tag, input logic [IDW-1:0] id, input logic [AW-1:0] addr,
                               input int len, input logic [1:0] burst, input logic [SW-1:0] strb,
                               input logic [DW-1:0] dataBase, input bit wlastFirst, input bit gaps,
                               input int abortAfter, input int breadyHold);
    int waitCnt;
    int beats;
    bit err;
    bit lastBad;
    bit wl;
    logic [DW-1:0] d;
    logic [SW-1:0] s;
    logic [MAW-1:0] base;
    beat_t e;
    base = addr[DS +: MAW];
    err = modelErr(burst, len);
    lastBad = 1'b0;
    beats = (abortAfter >= 0) ? abortAfter : len + 1;
    s_axi4_bready = (breadyHold == 0);

    waitCnt = 0;
    while (s_axi4_awready !== 1'b1 && waitCnt < 50) begin
      @(negedge clk);
      waitCnt++;
    end
    checkOutput({tag, "_awready_wait"}, 64'(waitCnt < 50), 64'(1));
    s_axi4_awvalid = 1'b1;
    s_axi4_awid = id;
    s_axi4_awaddr = addr;
    s_axi4_awlen = LW'(len);
    s_axi4_awburst = burst;
    @(negedge clk);
    s_axi4_awvalid = 1'b0;
    checkOutput({tag, "_awready_drop"}, 64'(s_axi4_awready), 64'(0));
    checkOutput({tag, "_wready_rise"}, 64'(s_axi4_wready), 64'(1));

    for (int i = 0; i < beats; i++) begin
      if (gaps && i > 0) begin
        s_axi4_wvalid = 1'b0;
        @(negedge clk);
      end
      d = (dataBase != '0) ? dataBase + DW'(i) : DW'($urandom);
      s = (strb != '0) ? strb : SW'($urandom_range(1, 15));
      wl = wlastFirst ? (i == 0) : (i == len);
      if (wl != (i == len)) lastBad = 1'b1;
      s_axi4_wvalid = 1'b1;
      s_axi4_wdata = d;
      s_axi4_wstrb = s;
      s_axi4_wlast = wl;
      waitCnt = 0;
      while (s_axi4_wready !== 1'b1 && waitCnt < 50) begin
        @(negedge clk);
        waitCnt++;
      end
      checkOutput({tag, "_wready_wait"}, 64'(waitCnt < 50), 64'(1));
      @(negedge clk);
      e.addr = modelAddr(base, burst, len, i);
      e.we = err ? '0 : s;
      e.data = d;
      e.careAddr = !err;
      expQ.push_back(e);
    end
    s_axi4_wvalid = 1'b0;
    s_axi4_wlast = 1'b0;
    if (abortAfter >= 0) return;

    checkOutput({tag, "_wready_low"}, 64'(s_axi4_wready), 64'(0));
    checkOutput({tag, "_bvalid"}, 64'(s_axi4_bvalid), 64'(1));
    checkOutput({tag, "_bid"}, 64'(s_axi4_bid), 64'(id));
    checkOutput({tag, "_bresp"}, 64'(s_axi4_bresp), 64'((err || lastBad) ? 2 : 0));
    for (int k = 0; k < breadyHold; k++) begin
      @(negedge clk);
      checkOutput({tag, "_hold_bvalid"}, 64'(s_axi4_bvalid), 64'(1));
      checkOutput({tag, "_hold_bid"}, 64'(s_axi4_bid), 64'(id));
      checkOutput({tag, "_hold_bresp"}, 64'(s_axi4_bresp), 64'((err || lastBad) ? 2 : 0));
      checkOutput({tag, "_hold_awready"}, 64'(s_axi4_awready), 64'(0));
    end
    s_axi4_bready = 1'b1;
    @(negedge clk);
    checkOutput({tag, "_bvalid_drop"}, 64'(s_axi4_bvalid), 64'(0));
    checkOutput({tag, "_awready_back"}, 64'(s_axi4_awready), 64'(1));
    compareWrites(tag);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_awready"}, 64'(s_axi4_awready), 64'(0));
    checkOutput({tag, "_wready"}, 64'(s_axi4_wready), 64'(0));
    checkOutput({tag, "_bvalid"}, 64'(s_axi4_bvalid), 64'(0));
    checkOutput({tag, "_bid"}, 64'(s_axi4_bid), 64'(0));
    checkOutput({tag, "_bresp"}, 64'(s_axi4_bresp), 64'(0));
    checkOutput({tag, "_mem_en"}, 64'(m_mem_en), 64'(0));
    checkOutput({tag, "_mem_we"}, 64'(m_mem_we), 64'(0));
    checkOutput({tag, "_mem_addr"}, 64'(m_mem_addr), 64'(0));
    checkOutput({tag, "_mem_wdata"}, 64'(m_mem_wdata), 64'(0));
  endtask

  initial begin : stimulus
    repeat (3) @(negedge clk);
    checkAllZero("reset");
    rst_n = 1'b1;
    #1;
    checkOutput("reset_awready_still_low", 64'(s_axi4_awready), 64'(0));
    @(negedge clk);
    checkOutput("reset_awready_rise", 64'(s_axi4_awready), 64'(1));

    applyStimulus("incr", 6'h15, 32'h10, 3, 2'd1, 4'hF, 32'hA0, 1'b0, 1'b0, -1, 0);
    applyStimulus("wrap4", 6'h21, 32'h18, 3, 2'd2, 4'hF, 32'h0, 1'b0, 1'b0, -1, 0);
    applyStimulus("wrap_bad", 6'h02, 32'h18, 2, 2'd2, 4'hF, 32'h0, 1'b0, 1'b0, -1, 0);
    applyStimulus("fixed", 6'h07, 32'h20, 2, 2'd0, 4'h3, 32'h0, 1'b0, 1'b0, -1, 0);
    applyStimulus("reserved", 6'h3F, 32'h30, 1, 2'd3, 4'hF, 32'h0, 1'b0, 1'b0, -1, 0);
    applyStimulus("wlast_early", 6'h11, 32'h40, 1, 2'd1, 4'hC, 32'h0, 1'b1, 1'b0, -1, 0);
    applyStimulus("gaps", 6'h12, 32'h44, 3, 2'd1, 4'h0, 32'h0, 1'b0, 1'b1, -1, 0);
    applyStimulus("bready_hold", 6'h2A, 32'h80, 2, 2'd1, 4'h0, 32'h0, 1'b0, 1'b0, -1, 5);
    applyStimulus("back2back", 6'h2B, 32'h90, 0, 2'd1, 4'h0, 32'h0, 1'b0, 1'b0, -1, 0);

    applyStimulus("abort", 6'h05, 32'h100, 7, 2'd1, 4'hF, 32'h0, 1'b0, 1'b0, 2, 0);
    rst_n = 1'b0;
    #1;
    checkAllZero("midreset");
    repeat (3) @(negedge clk);
    checkOutput("midreset_no_bvalid", 64'(s_axi4_bvalid), 64'(0));
    compareWrites("abort");
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("midreset_awready_rise", 64'(s_axi4_awready), 64'(1));
    applyStimulus("top_of_mem", 6'h09, 32'hFFC, 0, 2'd1, 4'hF, 32'h0, 1'b0, 1'b0, -1, 0);

    for (int r = 0; r < 12; r++) begin
      logic [1:0] bu;
      int ln;
      bu = 2'($urandom_range(0, 3));
      if (bu == 2'd2) begin
        case ($urandom_range(0, 4))
          0:       ln = 1;
          1:       ln = 3;
          2:       ln = 7;
          3:       ln = 15;
          default: ln = int'($urandom_range(0, 15));
        endcase
      end else begin
        ln = int'($urandom_range(0, 9));
      end
      applyStimulus("rand", IDW'($urandom), $urandom, ln, bu, 4'h0, 32'h0, 1'b0,
                    $urandom_range(0, 1) == 1, -1, int'($urandom_range(0, 2)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
